// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: captures decoded control, operands and register numbers for Execute.
// Supports freeze (hold), flush (bubble) and a deferred flush; optional counters via IDEXE_PERF_CNT_EN.
module id_exe_stage_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        freeze,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic        imm_in,
  input  logic [3:0]  EXE_CMD_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn_in,
  input  logic [31:0] Val_Rm_in,
  input  logic [11:0] Shift_operand_in,
  input  logic [23:0] Signed_imm_24_in,
  input  logic [3:0]  Dest_in,
  input  logic [3:0]  SR_in,
  input  logic [3:0]  src_1_in,
  input  logic [3:0]  src_2_in,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic        B_out,
  output logic        S_out,
  output logic        imm_out,
  output logic [3:0]  EXE_CMD_out,
  output logic [31:0] PC_out,
  output logic [31:0] Val_Rn_out,
  output logic [31:0] Val_Rm_out,
  output logic [11:0] Shift_operand_out,
  output logic [23:0] Signed_imm_24_out,
  output logic [3:0]  Dest_out,
  output logic [3:0]  SR_out,
  output logic [3:0]  src_1_out,
  output logic [3:0]  src_2_out,
  output logic        valid_out,
`ifdef IDEXE_PERF_CNT_EN
  output logic [15:0] bubble_count,
  output logic [15:0] freeze_count,
`endif
  output logic        flush_pending
);

  typedef enum logic {StIdle, StPend} pend_state_e;

  pend_state_e r_state;

  logic        r_wb_en;
  logic        r_mem_r_en;
  logic        r_mem_w_en;
  logic        r_b;
  logic        r_s;
  logic        r_imm;
  logic [3:0]  r_exe_cmd;
  logic [31:0] r_pc;
  logic [31:0] r_val_rn;
  logic [31:0] r_val_rm;
  logic [11:0] r_shift_operand;
  logic [23:0] r_signed_imm_24;
  logic [3:0]  r_dest;
  logic [3:0]  r_sr;
  logic [3:0]  r_src_1;
  logic [3:0]  r_src_2;
  logic        r_valid;

  logic w_bubble;
  logic w_load;

  // Freeze dominates; a pending flush turns the first unfrozen edge into a bubble.
  assign w_bubble = !freeze && (flush || (r_state == StPend));
  assign w_load   = !freeze && !flush && (r_state == StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle: if (freeze && flush) r_state <= StPend;
        StPend: if (!freeze) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en         <= 1'b0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_imm           <= 1'b0;
      r_exe_cmd       <= 4'h0;
      r_pc            <= 32'h0;
      r_val_rn        <= 32'h0;
      r_val_rm        <= 32'h0;
      r_shift_operand <= 12'h0;
      r_signed_imm_24 <= 24'h0;
      r_dest          <= 4'h0;
      r_sr            <= 4'h0;
      r_src_1         <= 4'h0;
      r_src_2         <= 4'h0;
      r_valid         <= 1'b0;
    end else if (w_bubble) begin
      // Fully zeroed bubble keeps downstream state deterministic.
      r_wb_en         <= 1'b0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_imm           <= 1'b0;
      r_exe_cmd       <= 4'h0;
      r_pc            <= 32'h0;
      r_val_rn        <= 32'h0;
      r_val_rm        <= 32'h0;
      r_shift_operand <= 12'h0;
      r_signed_imm_24 <= 24'h0;
      r_dest          <= 4'h0;
      r_sr            <= 4'h0;
      r_src_1         <= 4'h0;
      r_src_2         <= 4'h0;
      r_valid         <= 1'b0;
    end else if (w_load) begin
      r_wb_en         <= WB_EN_in;
      r_mem_r_en      <= MEM_R_EN_in;
      r_mem_w_en      <= MEM_W_EN_in;
      r_b             <= B_in;
      r_s             <= S_in;
      r_imm           <= imm_in;
      r_exe_cmd       <= EXE_CMD_in;
      r_pc            <= PC_in;
      r_val_rn        <= Val_Rn_in;
      r_val_rm        <= Val_Rm_in;
      r_shift_operand <= Shift_operand_in;
      r_signed_imm_24 <= Signed_imm_24_in;
      r_dest          <= Dest_in;
      r_sr            <= SR_in;
      r_src_1         <= src_1_in;
      r_src_2         <= src_2_in;
      r_valid         <= 1'b1;
    end
  end

`ifdef IDEXE_PERF_CNT_EN
  logic [15:0] r_bubble_cnt;
  logic [15:0] r_freeze_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= 16'h0;
      r_freeze_cnt <= 16'h0;
    end else begin
      if (w_bubble && (r_bubble_cnt != 16'hFFFF)) r_bubble_cnt <= r_bubble_cnt + 16'd1;
      if (freeze && (r_freeze_cnt != 16'hFFFF)) r_freeze_cnt <= r_freeze_cnt + 16'd1;
    end
  end

  assign bubble_count = r_bubble_cnt;
  assign freeze_count = r_freeze_cnt;
`endif

  assign WB_EN_out         = r_wb_en;
  assign MEM_R_EN_out      = r_mem_r_en;
  assign MEM_W_EN_out      = r_mem_w_en;
  assign B_out             = r_b;
  assign S_out             = r_s;
  assign imm_out           = r_imm;
  assign EXE_CMD_out       = r_exe_cmd;
  assign PC_out            = r_pc;
  assign Val_Rn_out        = r_val_rn;
  assign Val_Rm_out        = r_val_rm;
  assign Shift_operand_out = r_shift_operand;
  assign Signed_imm_24_out = r_signed_imm_24;
  assign Dest_out          = r_dest;
  assign SR_out            = r_sr;
  assign src_1_out         = r_src_1;
  assign src_2_out         = r_src_2;
  assign valid_out         = r_valid;
  assign flush_pending     = (r_state == StPend);

endmodule
